// File: rtl/sm4_pkg.sv
// rtl/sm4_pkg.sv - shared SM4 key-schedule constants, FSM state type and CK generator
//
// Purpose: FK system parameters, controller state enum, round-key count and an
//          arithmetic CK[i] generator shared by the key-expansion blocks.
// Ports:   none (package).

package sm4_pkg;

    localparam int RK_NUM = 32;

    localparam logic [31:0] FK0 = 32'hA3B1_BAC6;
    localparam logic [31:0] FK1 = 32'h56AA_3350;
    localparam logic [31:0] FK2 = 32'h677D_9197;
    localparam logic [31:0] FK3 = 32'hB270_22DC;
    localparam logic [127:0] FK = {FK0, FK1, FK2, FK3};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Byte j of CK[i] is ((4i+j)*7) mod 256; everything is kept 8 bits wide so
    // the product truncates naturally instead of needing a 256-entry table.
    function automatic logic [31:0] ck_gen(input logic [4:0] idx);
        logic [7:0] base;
        logic [7:0] b0, b1, b2, b3;
        base = {1'b0, idx, 2'b00};
        b0 = base * 8'd7;
        b1 = (base + 8'd1) * 8'd7;
        b2 = (base + 8'd2) * 8'd7;
        b3 = (base + 8'd3) * 8'd7;
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/SM4_KEY_EXP_ONE_ROUND.sv
// rtl/SM4_KEY_EXP_ONE_ROUND.sv - one combinational SM4 key-expansion round
//
// Purpose: rk = K0 ^ L'(tau(K1 ^ K2 ^ K3 ^ CK)), L'(B) = B ^ (B<<<13) ^ (B<<<23).
// Ports:   kin (128) {K0,K1,K2,K3}, ck (32) round constant, rk (32) new round key.

module SM4_KEY_EXP_ONE_ROUND (
    input  logic [127:0] kin,
    input  logic [31:0]  ck,
    output logic [31:0]  rk
);

    logic [31:0] t_in;
    logic [31:0] b;
    logic [31:0] l_out;

    assign t_in = kin[95:64] ^ kin[63:32] ^ kin[31:0] ^ ck;

    SM4_SBOX u_sbox0 (.din(t_in[31:24]), .dout(b[31:24]));
    SM4_SBOX u_sbox1 (.din(t_in[23:16]), .dout(b[23:16]));
    SM4_SBOX u_sbox2 (.din(t_in[15:8]),  .dout(b[15:8]));
    SM4_SBOX u_sbox3 (.din(t_in[7:0]),   .dout(b[7:0]));

    assign l_out = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    assign rk    = kin[127:96] ^ l_out;

endmodule

// File: rtl/SM4_SBOX.sv
// rtl/SM4_SBOX.sv - SM4 8-bit substitution box
//
// Purpose: combinational byte substitution tau.
// Ports:   din (8) byte in, dout (8) substituted byte.

module SM4_SBOX (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/sm4_key_exp_ctrl.sv
// rtl/sm4_key_exp_ctrl.sv - iterative SM4 key-schedule controller with round-key file
//
// Purpose: accepts a master key, runs 32 key-expansion rounds (one per clock)
//          and stores rk[0..31] in a flop file with a registered read port.
// Ports:   clk, rst (sync, active-high)
//          key_vld/key_in (128)/key_rdy  master key handshake
//          busy, done (1-cycle pulse), rk_valid  status
//          rk_rd_idx (5) -> rk_rd_data (32)  registered round-key read

module sm4_key_exp_ctrl
    import sm4_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         key_vld,
    input  logic [127:0] key_in,
    output logic         key_rdy,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic [4:0]   rk_rd_idx,
    output logic [31:0]  rk_rd_data
);

    state_t        state, state_nxt;
    logic [4:0]    cnt;
    logic [127:0]  kreg;
    logic [31:0]   rk_file [RK_NUM];
    logic [31:0]   ck_cur;
    logic [31:0]   rk_new;
    logic          accept;
    logic          last_round;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        key_rdy    = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        last_round = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                key_rdy = 1'b1;
                if (key_vld) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                busy = 1'b1;
                if (cnt == 5'd31) begin
                    last_round = 1'b1;
                    state_nxt  = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign ck_cur = ck_gen(cnt);

    SM4_KEY_EXP_ONE_ROUND u_round (
        .kin (kreg),
        .ck  (ck_cur),
        .rk  (rk_new)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= 5'd0;
            kreg       <= 128'd0;
            done       <= 1'b0;
            rk_valid   <= 1'b0;
            rk_rd_data <= 32'd0;
            for (int i = 0; i < RK_NUM; i++) begin
                rk_file[i] <= 32'd0;
            end
        end else begin
            // Read sees the file before this edge's write (no bypass).
            rk_rd_data <= rk_file[rk_rd_idx];
            done       <= last_round;
            if (accept) begin
                kreg     <= key_in ^ FK;
                cnt      <= 5'd0;
                rk_valid <= 1'b0;
            end else if (busy) begin
                rk_file[cnt] <= rk_new;
                kreg         <= {kreg[95:0], rk_new};
                if (last_round) begin
                    rk_valid <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sm4_key_exp_ctrl.sv
// tb/tb_sm4_key_exp_ctrl.sv - self-checking bench for sm4_key_exp_ctrl

module tb_sm4_key_exp_ctrl;

    localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] ZERO_KEY = 128'd0;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_vld;
    logic [127:0] key_in;
    logic         key_rdy;
    logic         busy;
    logic         done;
    logic         rk_valid;
    logic [4:0]   rk_rd_idx;
    logic [31:0]  rk_rd_data;

    int total = 0;
    int bad   = 0;
    int lat;
    int ndone;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    sm4_key_exp_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .key_vld    (key_vld),
        .key_in     (key_in),
        .key_rdy    (key_rdy),
        .busy       (busy),
        .done       (done),
        .rk_valid   (rk_valid),
        .rk_rd_idx  (rk_rd_idx),
        .rk_rd_data (rk_rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a read index and queue its expected data; the registered result
    // is popped and compared one edge later.
    task automatic rd_push(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        rk_rd_idx = idx;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic rd_pop();
        logic [31:0] e;
        string t;
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, rk_rd_data, e);
        end
    endtask

    task automatic rd(input logic [4:0] idx, input logic [31:0] exp, input string tag);
        rd_push(idx, exp, tag);
        tick();
        rd_pop();
    endtask

    // Count cycles after the accept edge until done, bounded.
    task automatic wait_done(input string tag);
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk(tag, lat, 32'd32);
    endtask

    initial begin
        rst       = 1'b1;
        key_vld   = 1'b0;
        key_in    = '0;
        rk_rd_idx = 5'd0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_key_rdy", {31'd0, key_rdy}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rk_valid", {31'd0, rk_valid}, 32'd0);
        chk("rst_rd_data", rk_rd_data, 32'd0);

        // Standard vector with CK probes and latency.
        key_in  = STD_KEY;
        key_vld = 1'b1;
        tick();
        key_vld = 1'b0;
        lat = 0;
        chk("exp_busy", {31'd0, busy}, 32'd1);
        chk("exp_key_rdy", {31'd0, key_rdy}, 32'd0);
        chk("ck0", dut.u_round.ck, 32'h00070E15);
        tick();
        lat++;
        chk("ck1", dut.u_round.ck, 32'h1C232A31);
        while (!done && lat < 40) begin
            tick();
            lat++;
            if (lat == 31) chk("ck31", dut.u_round.ck, 32'h646B7279);
        end
        chk("std_latency", lat, 32'd32);
        chk("done_rk_valid", {31'd0, rk_valid}, 32'd1);
        chk("done_busy", {31'd0, busy}, 32'd0);
        chk("done_key_rdy", {31'd0, key_rdy}, 32'd1);
        tick();
        chk("done_pulse_len", {31'd0, done}, 32'd0);
        rd(5'd0, 32'hF12186F9, "std_rk0");
        rd(5'd1, 32'h41662B61, "std_rk1");
        rd(5'd31, 32'h9124A012, "std_rk31");

        // Back-pressure: second key offered mid-expansion, held until accepted.
        key_in  = STD_KEY;
        key_vld = 1'b1;
        tick();
        key_vld = 1'b0;
        lat = 0;
        while (lat < 10) begin
            tick();
            lat++;
        end
        key_in  = ZERO_KEY;
        key_vld = 1'b1;
        chk("bp_key_rdy", {31'd0, key_rdy}, 32'd0);
        wait_done("bp_latency");
        chk("bp_accept_rdy", {31'd0, key_rdy}, 32'd1);
        rd_push(5'd0, 32'hF12186F9, "bp_rk0_kept");
        tick();
        key_vld = 1'b0;
        rd_pop();
        lat = 0;
        chk("rekey_rk_valid", {31'd0, rk_valid}, 32'd0);
        chk("rekey_busy", {31'd0, busy}, 32'd1);
        wait_done("rekey_latency");
        chk("rekey_rk_valid_hi", {31'd0, rk_valid}, 32'd1);
        tick();
        rd(5'd0, 32'h45603B23, "zero_rk0");

        // Mid-expansion reset.
        key_in  = STD_KEY;
        key_vld = 1'b1;
        tick();
        key_vld = 1'b0;
        lat = 0;
        while (lat < 15) begin
            tick();
            lat++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_key_rdy", {31'd0, key_rdy}, 32'd1);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_done", {31'd0, done}, 32'd0);
        chk("mr_rk_valid", {31'd0, rk_valid}, 32'd0);
        chk("mr_rd_data", rk_rd_data, 32'd0);
        ndone = 0;
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 32'd0, $sformatf("mr_rk%0d", i));
            if (done) ndone++;
        end
        chk("mr_no_done", ndone, 32'd0);

        // Reset and key_vld on the same edge.
        rst     = 1'b1;
        key_vld = 1'b1;
        key_in  = STD_KEY;
        tick();
        rst     = 1'b0;
        key_vld = 1'b0;
        chk("rp_busy", {31'd0, busy}, 32'd0);
        chk("rp_key_rdy", {31'd0, key_rdy}, 32'd1);
        tick();
        chk("rp_busy_later", {31'd0, busy}, 32'd0);
        chk("rp_rk_valid", {31'd0, rk_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm4_key_exp_ctrl.md
# sm4_key_exp_ctrl

Iterative SM4 key-schedule controller. Accepts a 128-bit master key, applies FK, runs 32 rounds through one `SM4_KEY_EXP_ONE_ROUND` instance (one round per clock), and stores all 32 round keys in an internal register file. The SM4 cipher/CTR datapath reads round keys from that file through an indexed read port.

## Interface
Parameters: none. SM4 constants are fixed by the standard.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `key_vld`  in  1  master key offered.
- `key_in`  in  128  master key MK0..MK3; MK0 = `[127:96]`.
- `key_rdy`  out  1  key can be accepted. High in IDLE and DONE.
- `busy`  out  1  expansion in progress (EXPAND state).
- `done`  out  1  one-cycle pulse when all 32 round keys are written.
- `rk_valid`  out  1  register file holds a complete schedule for the last accepted key.
- `rk_rd_idx`  in  5  round-key index to read (0..31).
- `rk_rd_data`  out  32  rk[`rk_rd_idx`], registered.

## Operation
- FSM states:
  - IDLE: reset state.
  - IDLE/DONE to EXPAND: on `key_vld & key_rdy`.
  - EXPAND to DONE: after round 31 is written.
  - DONE holds until a new key is accepted.
- Key acceptance:
  - State register ← {MK0^FK0, MK1^FK1, MK2^FK2, MK3^FK3}.
  - Round counter `cnt` ← 0.
  - `rk_valid` ← 0.
- Each EXPAND cycle:
  - The one-round instance receives the state and CK[`cnt`].
  - rk[`cnt`] ← round output.
  - State ← {K1, K2, K3, rk} (shift left one word).
  - `cnt` ← `cnt`+1.
- CK generation is arithmetic, with no ROM. Byte j (j=0 is MSB) of CK[i] = ((4i+j)·7) mod 256, using an 8-bit truncated product.
- `key_vld` during EXPAND is ignored: `key_rdy`=0 and the key is not latched. The upstream must hold it.
- Accepting a key in DONE restarts expansion and drops `rk_valid` at that edge.
- Reads are allowed in any state. During EXPAND, returned data may be stale or partial. Consumers must gate on `rk_valid`.
- Decrypt order is the consumer's job: it reads index 31−r.

## Timing
- Reset values:
  - state = IDLE, `cnt` = 0.
  - `key_rdy` = 1, `busy` = 0, `done` = 0, `rk_valid` = 0.
  - `rk_rd_data` = 0, all rk entries = 0.
- Accept edge E0 (`key_vld & key_rdy` sampled high):
  - Cycle after E0: `busy`=1, `key_rdy`=0.
  - rk[i] is written at edge E0+1+i.
  - After edge E0+32: `done`=1 for exactly one cycle, `rk_valid`=1, `busy`=0, `key_rdy`=1.
  - Total latency: 32 cycles from accept to `done`.
- Read latency: 1 cycle. `rk_rd_data` after edge N reflects `rk_rd_idx` sampled at edge N and the file contents before edge N's write.
- `cnt` reaching 31: no wrap. The FSM leaves EXPAND on that edge.
- `rst` asserted mid-EXPAND: everything returns to reset values at the next edge, including clearing the rk file. No `done` is emitted.
- `rst` and `key_vld` both high on the same edge: reset wins.

## Structure
- Shared package `sm4_pkg`: FK0..FK3 constants, state enum (IDLE/EXPAND/DONE), round-key count (32), CK generation function.
- Sub-module: one `SM4_KEY_EXP_ONE_ROUND` instance (which instantiates `SM4_SBOX` ×4). No other sub-module.
- Round-key file: 32×32 flip-flop array with one write port and one registered read port.

## Test plan
- Standard vector: MK=0123456789ABCDEFFEDCBA9876543210.
  - Expect `done` exactly 32 cycles after accept.
  - Expect rk[0]=F12186F9, rk[1]=41662B61, rk[31]=9124A012, each read with 1-cycle latency.
- CK check: probe the round-instance input. CK[0]=00070E15, CK[1]=1C232A31, CK[31]=646B7279.
- Back-pressure:
  - Drive a second key at cycle 10 of EXPAND.
  - `key_rdy`=0 and the key is ignored.
  - The first schedule completes unchanged.
  - The second key is accepted the cycle `done` is high.
- Re-key from DONE: accept MK=0.
  - `rk_valid` falls the next cycle.
  - `done` follows 32 cycles later.
  - rk[0] differs from the standard-vector rk[0].
- Mid-operation reset:
  - Assert `rst` at EXPAND cycle 15.
  - Next cycle: all outputs at reset values, reads of idx 0..31 return 0, no `done` pulse.
- Reset priority: `rst` and `key_vld` high on the same edge. Result: IDLE, `busy`=0, no expansion starts.
